// File: rtl/mdio_responder_if.sv
// MDIO line plus parallel register port between the management side and the responder.
interface mdio_responder_if;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        reg_we;
  logic        frame_err;

  modport master (
    output mdc, mdio_in, reg_rdata,
    input  mdio_out, mdio_oe, reg_addr, reg_wdata, reg_we, frame_err
  );

  modport slave (
    input  mdc, mdio_in, reg_rdata,
    output mdio_out, mdio_oe, reg_addr, reg_wdata, reg_we, frame_err
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause 22 MDIO responder: outputs move 2 clk after an mdc edge; no backpressure, the controller paces frames.
// Optional preamble check (32 sampled ones before ST) under MDIO_RESPONDER_PREAMBLE_CHECK_EN.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input logic             clk,
  input logic             reset,
  mdio_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
  } state_t;

  state_t      state, state_n;
  logic        mdc_q, rise, fall, din;
  logic [4:0]  fcnt, fcnt_n;
  logic [15:0] sr, sr_n, shin;
  logic        rd, rd_n, op_bad, op_bad_n, hold, hold_n;
  logic        out_q, out_n, oe_q, oe_n, we_q, we_n, err_q, err_n;
  logic [4:0]  addr_q, addr_n;
  logic [15:0] wdata_q, wdata_n;
`ifdef MDIO_RESPONDER_PREAMBLE_CHECK_EN
  logic [5:0]  pcnt, pcnt_n;
`endif

  assign shin = {sr[14:0], din};

  // rise/fall and the sampled data bit are registered together so they stay aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_q <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      din   <= 1'b0;
    end else begin
      mdc_q <= bus.mdc;
      rise  <= bus.mdc & ~mdc_q;
      fall  <= ~bus.mdc & mdc_q;
      din   <= bus.mdio_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      fcnt    <= 5'd0;
      sr      <= 16'd0;
      rd      <= 1'b0;
      op_bad  <= 1'b0;
      hold    <= 1'b0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 16'd0;
`ifdef MDIO_RESPONDER_PREAMBLE_CHECK_EN
      pcnt    <= 6'd0;
`endif
    end else begin
      state   <= state_n;
      fcnt    <= fcnt_n;
      sr      <= sr_n;
      rd      <= rd_n;
      op_bad  <= op_bad_n;
      hold    <= hold_n;
      out_q   <= out_n;
      oe_q    <= oe_n;
      we_q    <= we_n;
      err_q   <= err_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
`ifdef MDIO_RESPONDER_PREAMBLE_CHECK_EN
      pcnt    <= pcnt_n;
`endif
    end
  end

  // fcnt is the absolute frame bit index (ST bit 1 = 0); it wraps to 0 after bit 31
  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    sr_n     = sr;
    rd_n     = rd;
    op_bad_n = op_bad;
    hold_n   = hold;
    out_n    = out_q;
    oe_n     = oe_q;
    we_n     = 1'b0;
    err_n    = 1'b0;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
`ifdef MDIO_RESPONDER_PREAMBLE_CHECK_EN
    pcnt_n   = pcnt;
`endif
    if (rise) begin
      case (state)
        S_IDLE: begin
`ifdef MDIO_RESPONDER_PREAMBLE_CHECK_EN
          if (din) begin
            pcnt_n = (pcnt == 6'd32) ? pcnt : pcnt + 6'd1;
          end else if (pcnt == 6'd32) begin
            state_n = S_ST;
            fcnt_n  = 5'd1;
            pcnt_n  = 6'd0;
          end else begin
            pcnt_n  = 6'd0;
          end
`else
          if (!din) begin
            state_n = S_ST;
            fcnt_n  = 5'd1;
          end
`endif
        end
        S_ST: begin
          if (din) begin
            state_n = S_OP;
            fcnt_n  = fcnt + 5'd1;
          end else begin
            state_n = S_IDLE;
            fcnt_n  = 5'd0;
          end
        end
        S_OP: begin
          fcnt_n = fcnt + 5'd1;
          if (fcnt == 5'd2) begin
            hold_n = din;
          end else begin
            rd_n     = hold & ~din;
            op_bad_n = (hold == din);
            state_n  = S_PHYAD;
          end
        end
        S_PHYAD: begin
          fcnt_n = fcnt + 5'd1;
          sr_n   = shin;
          // a bad OP only counts as an error once we know the frame is ours
          if (fcnt == 5'd8) begin
            if (shin[4:0] != PHY_ADDR) begin
              state_n = S_SKIP;
            end else if (op_bad) begin
              err_n   = 1'b1;
              state_n = S_SKIP;
            end else begin
              state_n = S_REGAD;
            end
          end
        end
        S_REGAD: begin
          fcnt_n = fcnt + 5'd1;
          sr_n   = shin;
          if (fcnt == 5'd13) begin
            addr_n  = shin[4:0];
            state_n = S_TA;
          end
        end
        S_TA: begin
          fcnt_n = fcnt + 5'd1;
          if (!rd) begin
            if (fcnt == 5'd14) begin
              hold_n = din;
            end else if ({hold, din} == 2'b10) begin
              state_n = S_DATA;
            end else begin
              err_n   = 1'b1;
              state_n = S_SKIP;
            end
          end
        end
        S_DATA: begin
          fcnt_n = fcnt + 5'd1;
          if (!rd) begin
            sr_n = shin;
            if (fcnt == 5'd31) begin
              wdata_n = shin;
              we_n    = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
        S_SKIP: begin
          fcnt_n = fcnt + 5'd1;
          if (fcnt == 5'd31) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (fall) begin
      if (state == S_TA && rd && fcnt == 5'd15) begin
        sr_n    = bus.reg_rdata;
        oe_n    = 1'b1;
        out_n   = 1'b0;
        state_n = S_DATA;
      end else if (state == S_DATA && rd) begin
        if (fcnt == 5'd0) begin
          oe_n    = 1'b0;
          out_n   = 1'b0;
          state_n = S_IDLE;
        end else begin
          out_n = sr[15];
          sr_n  = {sr[14:0], 1'b0};
        end
      end
    end
  end

  assign bus.mdio_out  = out_q;
  assign bus.mdio_oe   = oe_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed-vector bench for mdio_responder: controller model on mdc/mdio_in, tiny register file on reg_rdata.
module tb_mdio_responder;
  logic clk;
  logic reset;
  mdio_responder_if bus();

  int n_chk = 0;
  int n_bad = 0;
  int n_we  = 0;
  int n_err = 0;
  int n_oe  = 0;
  int we0, err0, oe0;
  logic [4:0]  we_addr;
  logic [15:0] we_data;

`ifdef MDIO_RESPONDER_PREAMBLE_CHECK_EN
  localparam int SHORT_PRE_WE = 0;
`else
  localparam int SHORT_PRE_WE = 1;
`endif

  mdio_responder #(.PHY_ADDR(5'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.reg_addr)
      5'h03:   bus.reg_rdata = 16'h1234;
      5'h07:   bus.reg_rdata = 16'hFFFF;
      default: bus.reg_rdata = 16'h0000;
    endcase
  end

  always @(negedge clk) begin
    if (bus.reg_we) begin
      n_we++;
      we_addr = bus.reg_addr;
      we_data = bus.reg_wdata;
    end
    if (bus.frame_err) n_err++;
    if (bus.mdio_oe) n_oe++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic snap();
    we0  = n_we;
    err0 = n_err;
    oe0  = n_oe;
  endtask

  // one mdc period of 8 clk; the line is sampled just before mdc rises, as a controller would
  task automatic mdc_cycle(input logic b, output logic so, output logic soe);
    bus.mdio_in = b;
    repeat (4) @(negedge clk);
    so  = bus.mdio_out;
    soe = bus.mdio_oe;
    bus.mdc = 1'b1;
    repeat (4) @(negedge clk);
    bus.mdc = 1'b0;
  endtask

  task automatic send_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d,
                            output logic [31:0] so, output logic [31:0] soe);
    logic [31:0] f;
    logic o, e;
    f   = {2'b01, op, phy, ra, ta, d};
    so  = 32'd0;
    soe = 32'd0;
    for (int i = 0; i < npre; i++) mdc_cycle(1'b1, o, e);
    for (int i = 0; i < 32; i++) begin
      mdc_cycle(f[31-i], o, e);
      so[31-i]  = o;
      soe[31-i] = e;
    end
    bus.mdio_in = 1'b1;
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] so, soe, f;
    logic o, e;
    reset       = 1'b0;
    bus.mdc     = 1'b0;
    bus.mdio_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out",   32'(bus.mdio_out),  32'h0);
    chk("rst_oe",    32'(bus.mdio_oe),   32'h0);
    chk("rst_addr",  32'(bus.reg_addr),  32'h0);
    chk("rst_wdata", 32'(bus.reg_wdata), 32'h0);
    chk("rst_we",    32'(bus.reg_we),    32'h0);
    chk("rst_err",   32'(bus.frame_err), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    snap();
    send_frame(32, 2'b01, 5'd1, 5'h0A, 2'b10, 16'hBEEF, so, soe);
    chk("wr_we_cnt", n_we - we0, 32'd1);
    chk("wr_addr",   32'(we_addr), 32'h0A);
    chk("wr_data",   32'(we_data), 32'hBEEF);
    chk("wr_oe",     n_oe - oe0, 32'd0);
    chk("wr_err",    n_err - err0, 32'd0);
    repeat (20) @(negedge clk);
    chk("wr_hold_data", 32'(bus.reg_wdata), 32'hBEEF);
    chk("wr_hold_addr", 32'(bus.reg_addr), 32'h0A);

    snap();
    send_frame(32, 2'b10, 5'd1, 5'h03, 2'b11, 16'hFFFF, so, soe);
    chk("rd_bits",   so,  32'h0000_1234);
    chk("rd_oe_bits", soe, 32'h0001_FFFF);
    chk("rd_oe_clks", n_oe - oe0, 32'd136);
    chk("rd_oe_end", 32'(bus.mdio_oe), 32'h0);
    chk("rd_we",     n_we - we0, 32'd0);
    chk("rd_addr",   32'(bus.reg_addr), 32'h03);

    snap();
    send_frame(32, 2'b01, 5'd2, 5'h0B, 2'b10, 16'h1111, so, soe);
    chk("phy_miss_we",  n_we - we0, 32'd0);
    chk("phy_miss_err", n_err - err0, 32'd0);
    chk("phy_miss_oe",  n_oe - oe0, 32'd0);
    snap();
    send_frame(32, 2'b01, 5'd1, 5'h11, 2'b10, 16'h5AC3, so, soe);
    chk("after_miss_we",   n_we - we0, 32'd1);
    chk("after_miss_addr", 32'(we_addr), 32'h11);
    chk("after_miss_data", 32'(we_data), 32'h5AC3);

    snap();
    send_frame(32, 2'b01, 5'd1, 5'h12, 2'b11, 16'h7777, so, soe);
    chk("ta_bad_err", n_err - err0, 32'd1);
    chk("ta_bad_we",  n_we - we0, 32'd0);

    snap();
    send_frame(32, 2'b00, 5'd1, 5'h04, 2'b10, 16'h2222, so, soe);
    chk("op00_err", n_err - err0, 32'd1);
    chk("op00_we",  n_we - we0, 32'd0);
    chk("op00_oe",  n_oe - oe0, 32'd0);
    snap();
    send_frame(32, 2'b11, 5'd2, 5'h04, 2'b10, 16'h2222, so, soe);
    chk("op11_miss_err", n_err - err0, 32'd0);
    chk("op11_miss_oe",  n_oe - oe0, 32'd0);

    snap();
    f = {2'b01, 2'b10, 5'd1, 5'h07, 2'b11, 16'hFFFF};
    for (int i = 0; i < 32; i++) mdc_cycle(1'b1, o, e);
    for (int i = 0; i < 22; i++) mdc_cycle(f[31-i], o, e);
    repeat (3) @(negedge clk);
    chk("mid_oe_before",  32'(bus.mdio_oe),  32'h1);
    chk("mid_out_before", 32'(bus.mdio_out), 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_oe_reset",   32'(bus.mdio_oe),  32'h0);
    chk("mid_out_reset",  32'(bus.mdio_out), 32'h0);
    chk("mid_addr_reset", 32'(bus.reg_addr), 32'h0);
    repeat (2) @(negedge clk);
    bus.mdio_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_we", n_we - we0, 32'd0);
    send_frame(32, 2'b10, 5'd1, 5'h03, 2'b11, 16'hFFFF, so, soe);
    chk("post_rst_bits", so,  32'h0000_1234);
    chk("post_rst_oe",   soe, 32'h0001_FFFF);

    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    send_frame(31, 2'b01, 5'd1, 5'h15, 2'b10, 16'h0F0F, so, soe);
    chk("pre31_we", n_we - we0, SHORT_PRE_WE);
    snap();
    send_frame(32, 2'b01, 5'd1, 5'h16, 2'b10, 16'hF0F0, so, soe);
    chk("pre32_we",   n_we - we0, 32'd1);
    chk("pre32_addr", 32'(we_addr), 32'h16);
    chk("pre32_data", 32'(we_data), 32'hF0F0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
